dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 32-bit data words.
REQ-002 Parameter WAIT_CYCLES, default 2, legal range 0..15: wait states inserted between request acceptance and response.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  core presents a request.
REQ-006 req_ready  out  1  responder can accept a request this cycle.
REQ-007 req_we  in  1  1 = store, 0 = load.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  core consumes the response.
REQ-012 rsp_rdata  out  32  load data; 0 for stores and errors.
REQ-013 rsp_err  out  1  request was misaligned or out of range.
REQ-014 console_valid  out  1  one-cycle pulse on a committed store to byte address 0x0.
REQ-015 console_data  out  32  store data for that console store; holds its value between pulses.
REQ-016 halt  out  1  sticky flag, set by a committed store to byte address 0x4.

Function
REQ-017 The FSM SHALL have three states, IDLE, WAIT and RESP; req_ready SHALL equal (state==IDLE).
REQ-018 A request SHALL be accepted on an edge where req_valid && req_ready; req_we, req_addr and req_wdata SHALL be captured at that edge.
REQ-019 On acceptance, if WAIT_CYCLES>0 the FSM SHALL go IDLE->WAIT and load a down-counter with WAIT_CYCLES-1; if WAIT_CYCLES==0 it SHALL go IDLE->RESP.
REQ-020 In WAIT the FSM SHALL go to RESP on the edge where the counter equals 0, and otherwise decrement the counter.
REQ-021 rsp_valid SHALL first be high in the cycle after the (WAIT_CYCLES+1)th rising edge following the accepting edge.
REQ-022 Read data, write commit and the error check SHALL all take effect on the edge that enters RESP.
REQ-023 Error condition: captured addr[1:0]!=0, or addr[31:2]>=DEPTH_WORDS.
REQ-024 On error, rsp_err=1, rsp_rdata=0, no array write occurs and there are no console or halt side effects.
REQ-025 A load SHALL return array[addr[31:2]] in rsp_rdata with rsp_err=0.
REQ-026 A store SHALL write array[addr[31:2]] and return rsp_rdata=0 with rsp_err=0.
REQ-027 A store to 0x0 SHALL write the array, pulse console_valid for exactly one cycle (coincident with the first RESP cycle) and update console_data.
REQ-028 A store to 0x4 SHALL write the array and set halt=1; halt SHALL stay 1 until reset.
REQ-029 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1.
REQ-030 On the edge where rsp_valid && rsp_ready, the FSM SHALL return to IDLE; a request can therefore be accepted no earlier than the following edge.
REQ-031 req_valid in WAIT or RESP SHALL be ignored (req_ready=0); it has no effect on the FSM or the array.
REQ-032 Minimum issue interval is WAIT_CYCLES+2 cycles when rsp_ready is tied high.

Reset
REQ-033 While reset is high at an edge: state->IDLE, counter=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, console_valid=0, console_data=0, halt=0.
REQ-034 Reset asserted while in WAIT SHALL discard the pending request: no array write, no console pulse, no halt.
REQ-035 Reset asserted in RESP SHALL drop the response without requiring rsp_ready.
REQ-036 The array SHALL NOT be cleared by reset; its contents persist.

Structure
REQ-037 A shared package dmem_pkg SHALL hold the state type (IDLE/WAIT/RESP) and the constants CONSOLE_ADDR=32'h0 and HALT_ADDR=32'h4.
REQ-038 Storage SHALL be a sub-module dmem_array: one synchronous write port, one combinational read port, DEPTH_WORDS x 32, no reset.
REQ-039 The FSM, wait counter, request capture and MMIO logic SHALL reside in dmem_responder.

Verification
REQ-040 Stimulus: WAIT_CYCLES=2, store 0x0000_00AB to 0x8, then load 0x8 with rsp_ready=1. Required: each rsp_valid rises 3 edges after acceptance; load returns 0xAB with rsp_err=0.
REQ-041 Stimulus: load from 0x6, and separately store to 0x100 with DEPTH_WORDS=64. Required: rsp_err=1 and rsp_rdata=0 for both; a later load of 0x0 is unchanged.
REQ-042 Stimulus: store 32'd42 to 0x0, then store any value to 0x4. Required: console_valid pulses exactly once with console_data=42; halt=1 and stays 1 until reset.
REQ-043 Stimulus: hold rsp_ready=0 for 5 cycles in RESP while driving req_valid=1. Required: rsp_* stable, req_ready=0, the second request is not accepted until the cycle after the response handshake.
REQ-044 Stimulus: assert reset during WAIT of a store 0x55 to 0xC, after a prior store of 0x11 to 0xC. Required: next load of 0xC returns 0x11, halt=0, all outputs at their reset values.
REQ-045 Stimulus: WAIT_CYCLES=0, back-to-back loads with rsp_ready=1. Required: rsp_valid 1 edge after each acceptance; one request accepted every 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding and MMIO addresses.
package dmem_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam logic [31:0] CONSOLE_ADDR = 32'h0000_0000;
  localparam logic [31:0] HALT_ADDR    = 32'h0000_0004;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one combinational read port, never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder with a console register at 0x0 and a sticky halt flag at 0x4.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        console_valid,
  output logic [31:0] console_data,
  output logic        halt,
  output logic [1:0]  debug_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // Handshake: a transfer happens on any rising edge where valid && ready are both high;
  // req_ready is high only in IDLE, rsp_valid only in RESP, and RESP holds until rsp_ready.
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cap_we;
  logic [31:0]      cap_addr;
  logic [31:0]      cap_wdata;

  logic             accept;
  logic             enter_resp;
  logic             op_we;
  logic [31:0]      op_addr;
  logic [31:0]      op_wdata;
  logic             op_err;
  logic [31:0]      mem_rdata;
  logic             mem_we;

  assign req_ready   = (state == ST_IDLE);
  assign rsp_valid   = (state == ST_RESP);
  assign debug_state = state;
  assign accept      = req_valid && req_ready;

  // With zero wait states the operation commits on the accepting edge, so it uses the live request.
  always_comb begin
    op_we      = cap_we;
    op_addr    = cap_addr;
    op_wdata   = cap_wdata;
    enter_resp = 1'b0;
    if (state == ST_IDLE) begin
      op_we      = req_we;
      op_addr    = req_addr;
      op_wdata   = req_wdata;
      enter_resp = accept && (WAIT_CYCLES == 0);
    end else if (state == ST_WAIT) begin
      enter_resp = (cnt == '0);
    end
    op_err = (op_addr[1:0] != 2'b00) || (op_addr[31:2] >= 30'(DEPTH_WORDS));
    mem_we = enter_resp && op_we && !op_err;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .waddr(op_addr[AW+1:2]),
    .wdata(op_wdata),
    .raddr(op_addr[AW+1:2]),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      cap_we        <= 1'b0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      console_valid <= 1'b0;
      console_data  <= '0;
      halt          <= 1'b0;
    end else begin
      console_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cap_we    <= req_we;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_W'(WAIT_CYCLES - 1);
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (enter_resp) begin
        rsp_err   <= op_err;
        rsp_rdata <= (op_err || op_we) ? 32'h0 : mem_rdata;
        if (op_we && !op_err) begin
          if (op_addr == CONSOLE_ADDR) begin
            console_valid <= 1'b1;
            console_data  <= op_wdata;
          end
          if (op_addr == HALT_ADDR) begin
            halt <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: WAIT_CYCLES=2 instance (table, random, reset corners) and WAIT_CYCLES=0 instance.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, console_valid, halt;
  logic [31:0] req_addr, req_wdata, rsp_rdata, console_data;
  logic [1:0]  debug_state;

  logic        b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err, b_console_valid, b_halt;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata, b_console_data;
  logic [1:0]  b_debug_state;

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .console_valid(console_valid),
    .console_data(console_data), .halt(halt), .debug_state(debug_state)
  );

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .console_valid(b_console_valid),
    .console_data(b_console_data), .halt(b_halt), .debug_state(b_debug_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: word memory keyed by word index, plus MMIO side-effect state.
  logic [31:0] m_mem [int];
  logic [31:0] m_con;
  logic        m_halt;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_bit({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    check_bit({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check_bit({tag, "_console_valid"}, console_valid, 1'b0);
    check({tag, "_console_data"}, console_data, 32'h0);
    check_bit({tag, "_halt"}, halt, 1'b0);
    check_bit({tag, "_req_ready"}, req_ready, 1'b1);
  endtask

  // One full transaction on the WAIT_CYCLES=2 instance; called and returning at a falling edge.
  task automatic transact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, input logic keep_valid,
                          output logic [31:0] got_rdata, output logic got_err);
    logic        e, known, exp_con;
    logic [31:0] exp_rd;
    int          t;
    e       = (addr[1:0] != 2'b00) || ((addr >> 2) >= 32'd64);
    known   = !e && !we && m_mem.exists(int'(addr >> 2));
    exp_rd  = known ? m_mem[int'(addr >> 2)] : 32'h0;
    exp_con = we && !e && (addr == 32'h0);
    if (we && !e) begin
      m_mem[int'(addr >> 2)] = wdata;
      if (addr == 32'h0) m_con = wdata;
      if (addr == 32'h4) m_halt = 1'b1;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b0;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    check_bit("req_ready_wait", req_ready, 1'b1);
    @(negedge clk);
    req_valid = keep_valid;
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    check("rsp_latency", 32'(t), 32'd2);
    check_bit("req_ready_in_resp", req_ready, 1'b0);
    check_bit("rsp_err", rsp_err, e);
    if (e || we || known) check("rsp_rdata", rsp_rdata, exp_rd);
    check_bit("console_valid", console_valid, exp_con);
    check("console_data", console_data, m_con);
    check_bit("halt", halt, m_halt);
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_bit("hold_rsp_valid", rsp_valid, 1'b1);
      check("hold_rsp_rdata", rsp_rdata, got_rdata);
      check_bit("hold_rsp_err", rsp_err, got_err);
      check_bit("hold_req_ready", req_ready, 1'b0);
      check_bit("hold_console_valid", console_valid, 1'b0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_bit("rsp_valid_after_hs", rsp_valid, 1'b0);
    check_bit("req_ready_after_hs", req_ready, 1'b1);
  endtask

  initial begin
    logic [31:0] rd, addr, b_vals [4];
    logic        er, we;
    int          t, kind;

    reset = 1'b1;
    req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_rsp_ready = 0;
    m_con = 32'h0; m_halt = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    check_bit("b_reset_rsp_valid", b_rsp_valid, 1'b0);
    check("reset_state", 32'(debug_state), 32'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);

    // Zero wait states, back-to-back: four stores then four loads, one accepted every 2 cycles.
    for (int i = 0; i < 4; i++) b_vals[i] = $urandom;
    b_rsp_ready = 1'b1;
    b_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_req_we    = (i < 4);
      b_req_addr  = 32'((i % 4) + 1) << 2;
      b_req_wdata = b_vals[i % 4];
      check_bit("b_req_ready", b_req_ready, 1'b1);
      @(negedge clk);
      check_bit("b_rsp_valid", b_rsp_valid, 1'b1);
      check_bit("b_req_ready_busy", b_req_ready, 1'b0);
      check_bit("b_rsp_err", b_rsp_err, 1'b0);
      check("b_rsp_rdata", b_rsp_rdata, (i < 4) ? 32'h0 : b_vals[i % 4]);
      @(negedge clk);
    end
    b_req_valid = 1'b0;

    tbl[0] = '{1'b1, 32'h8,   32'h0000_00AB, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h8,   32'h0,         1'b0, 32'h0000_00AB};
    tbl[2] = '{1'b1, 32'h0,   32'd42,        1'b0, 32'h0};
    tbl[3] = '{1'b0, 32'h6,   32'h0,         1'b1, 32'h0};
    tbl[4] = '{1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 32'h0};
    tbl[5] = '{1'b0, 32'h0,   32'h0,         1'b0, 32'd42};
    tbl[6] = '{1'b1, 32'h4,   32'h9,         1'b0, 32'h0};
    tbl[7] = '{1'b0, 32'h4,   32'h0,         1'b0, 32'h9};
    for (int i = 0; i < 8; i++) begin
      transact(tbl[i].we, tbl[i].addr, tbl[i].wdata, i % 2, 1'b0, rd, er);
      check("tbl_rdata", rd, tbl[i].exp_rdata);
      check_bit("tbl_err", er, tbl[i].exp_err);
    end
    check("tbl_console_data", console_data, 32'd42);
    check_bit("tbl_halt", halt, 1'b1);

    // Stalled response with a competing request held high the whole time.
    transact(1'b0, 32'h8, 32'h0, 5, 1'b1, rd, er);
    check("stall_rdata", rd, 32'h0000_00AB);
    transact(1'b1, 32'h10, 32'h77, 0, 1'b0, rd, er);
    transact(1'b0, 32'h10, 32'h0, 0, 1'b0, rd, er);
    check("second_req_data", rd, 32'h77);

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 9);
      we   = 1'($urandom_range(0, 1));
      if (kind == 0)      addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else if (kind == 1) addr = 32'($urandom_range(64, 1000)) << 2;
      else                addr = 32'($urandom_range(0, 15)) << 2;
      transact(we, addr, $urandom, $urandom_range(0, 2), 1'b0, rd, er);
    end

    // Reset during WAIT of a store must discard it.
    transact(1'b1, 32'hC, 32'h11, 0, 1'b0, rd, er);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hC; req_wdata = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    check("wait_state", 32'(debug_state), 32'(ST_WAIT));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_halt = 1'b0; m_con = 32'h0;
    check_reset_vals("reset_in_wait");
    repeat (3) @(negedge clk);
    check_reset_vals("after_reset_wait");
    transact(1'b0, 32'hC, 32'h0, 0, 1'b0, rd, er);
    check("reset_wait_load", rd, 32'h11);

    // Reset in RESP drops the response without rsp_ready.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_wdata = 32'h0; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < 50) begin @(negedge clk); t++; end
    check_bit("resp_before_reset", rsp_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_vals("reset_in_resp");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
